// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encodings and counter width helper for the scan sequencer
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BLANK = 2'b01,
        ST_SHOW  = 2'b10
    } scan_state_t;

    // Width of a counter that must hold 0 .. prescale-1 (at least one bit)
    function automatic int cnt_width(input int prescale);
        return (prescale < 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/slot_counter.sv
// rtl/slot_counter.sv - modulo-MOD free-running counter with sync clear and terminal count
module slot_counter
    import scan_pkg::*;
#(
    parameter int MOD = 4,
    parameter int W   = cnt_width(MOD)
) (
    input  logic         clk,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign tc = (cnt == LAST);

    // Count every cycle, folding back to zero after the last position; clear wins
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - 2-bit select scanner with per-slot blanking for a 2-to-4 decoder
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int BLANK    = 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic Restart,
    output logic I1,
    output logic I0,
    output logic Valid,
    output logic Tick,
    output logic Wrap
);

    localparam int W = cnt_width(PRESCALE);

    // A slot starts blanked unless there is no blanking interval at all
    localparam scan_state_t SLOT_START = (BLANK == 0) ? ST_SHOW : ST_BLANK;

    scan_state_t  state;
    scan_state_t  state_next;
    logic [1:0]   idx;
    logic [1:0]   idx_next;
    logic         tick_next;
    logic         wrap_next;
    logic [W-1:0] cnt;
    logic         tc;
    logic         cnt_clr;

    // The slot position only advances while actually scanning
    assign cnt_clr = Rst | Restart | ~En | (state == ST_IDLE);

    slot_counter #(
        .MOD (PRESCALE),
        .W   (W)
    ) u_slot_counter (
        .clk (Clk),
        .clr (cnt_clr),
        .cnt (cnt),
        .tc  (tc)
    );

    assign I1 = idx[1];
    assign I0 = idx[0];

    // Next state, next index and pulse decisions; Restart outranks En, which outranks advance
    always_comb begin
        state_next = state;
        idx_next   = idx;
        tick_next  = 1'b0;
        wrap_next  = 1'b0;
        if (Restart) begin
            idx_next   = 2'd0;
            state_next = En ? SLOT_START : ST_IDLE;
        end else if (!En) begin
            state_next = ST_IDLE;
        end else if (state == ST_IDLE) begin
            state_next = SLOT_START;
        end else if (tc) begin
            idx_next   = idx + 2'd1;
            tick_next  = 1'b1;
            wrap_next  = (idx == 2'd3);
            state_next = SLOT_START;
        end else if (int'(cnt) + 1 >= BLANK) begin
            state_next = ST_SHOW;
        end else begin
            state_next = ST_BLANK;
        end
    end

    // State, index and registered outputs; Valid mirrors the SHOW state
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
            idx   <= 2'd0;
            Valid <= 1'b0;
            Tick  <= 1'b0;
            Wrap  <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            Valid <= (state_next == ST_SHOW);
            Tick  <= tick_next;
            Wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - randomized model-checked bench for scan_sequencer
module tb_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;
    logic restart;

    logic a_i1, a_i0, a_valid, a_tick, a_wrap;
    logic b_i1, b_i0, b_valid, b_tick, b_wrap;

    scan_sequencer #(.PRESCALE(4), .BLANK(1)) dut_a (
        .Clk(clk), .Rst(rst), .En(en), .Restart(restart),
        .I1(a_i1), .I0(a_i0), .Valid(a_valid), .Tick(a_tick), .Wrap(a_wrap)
    );

    scan_sequencer #(.PRESCALE(2), .BLANK(0)) dut_b (
        .Clk(clk), .Rst(rst), .En(en), .Restart(restart),
        .I1(b_i1), .I0(b_i0), .Valid(b_valid), .Tick(b_tick), .Wrap(b_wrap)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: running flag, cycles elapsed in the current slot, current index
    int mp[2] = '{4, 2};
    int mb[2] = '{1, 0};
    int m_run[2]  = '{0, 0};
    int m_pos[2]  = '{0, 0};
    int m_idx[2]  = '{0, 0};
    int m_tick[2] = '{0, 0};
    int m_wrap[2] = '{0, 0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_tick[d] = 0;
            m_wrap[d] = 0;
            if (rst) begin
                m_run[d] = 0; m_pos[d] = 0; m_idx[d] = 0;
            end else if (restart) begin
                m_idx[d] = 0; m_pos[d] = 0; m_run[d] = en ? 1 : 0;
            end else if (!en) begin
                m_run[d] = 0; m_pos[d] = 0;
            end else if (m_run[d] == 0) begin
                m_run[d] = 1; m_pos[d] = 0;
            end else if (m_pos[d] == mp[d] - 1) begin
                m_pos[d]  = 0;
                m_idx[d]  = (m_idx[d] + 1) % 4;
                m_tick[d] = 1;
                m_wrap[d] = (m_idx[d] == 0) ? 1 : 0;
            end else begin
                m_pos[d] = m_pos[d] + 1;
            end
        end
    end

    function automatic int m_valid(input int d);
        return (m_run[d] != 0 && m_pos[d] >= mb[d]) ? 1 : 0;
    endfunction

    bit chk_en = 1'b0;

    // Compare both DUTs against the model, including the Valid-gated decoder view
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] dec;
            check("a_sel",   {a_i1, a_i0}, m_idx[0]);
            check("a_valid", a_valid, m_valid(0));
            check("a_tick",  a_tick,  m_tick[0]);
            check("a_wrap",  a_wrap,  m_wrap[0]);
            dec = a_valid ? (4'b0001 << {a_i1, a_i0}) : 4'b0000;
            check("a_dec", dec, m_valid(0) != 0 ? (1 << m_idx[0]) : 0);
            check("b_sel",   {b_i1, b_i0}, m_idx[1]);
            check("b_valid", b_valid, m_valid(1));
            check("b_tick",  b_tick,  m_tick[1]);
            check("b_wrap",  b_wrap,  m_wrap[1]);
        end
    end

    int sel_log[20];
    int val_log[20];
    int bsel_log[20];
    int bval_log[20];
    int tick_q[$];
    int wrap_q[$];
    int d0_rise[$];

    initial begin
        rst = 1'b1; en = 1'b1; restart = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;

        // Reset held with En high: everything stays low
        repeat (2) begin
            @(negedge clk);
            check("rst_outs", {a_i1, a_i0, a_valid, a_tick, a_wrap}, 0);
        end
        rst = 1'b0;

        // Steady scan, 20 cycles counted from the first slot
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            sel_log[c]  = {a_i1, a_i0};
            val_log[c]  = a_valid;
            bsel_log[c] = {b_i1, b_i0};
            bval_log[c] = b_valid;
            if (a_tick) tick_q.push_back(c);
            if (a_wrap) wrap_q.push_back(c);
            if (c > 0 && a_valid && sel_log[c] == 0 && !(val_log[c-1] != 0 && sel_log[c-1] == 0))
                d0_rise.push_back(c);
        end
        for (int c = 0; c < 20; c++) begin
            check("steady_sel",   sel_log[c],  (c / 4) % 4);
            check("steady_valid", val_log[c],  (c % 4) != 0 ? 1 : 0);
            check("b_steady_sel", bsel_log[c], (c / 2) % 4);
            check("b_steady_valid", bval_log[c], 1);
        end
        check("tick_count", tick_q.size(), 4);
        if (tick_q.size() == 4) begin
            check("tick0", tick_q[0], 4);
            check("tick1", tick_q[1], 8);
            check("tick2", tick_q[2], 12);
            check("tick3", tick_q[3], 16);
        end
        check("wrap_count", wrap_q.size(), 1);
        if (wrap_q.size() == 1) check("wrap_at", wrap_q[0], 16);
        check("d0_count", d0_rise.size(), 2);
        if (d0_rise.size() == 2) begin
            check("d0_first", d0_rise[0], 1);
            check("d0_period", d0_rise[1] - d0_rise[0], 16);
        end

        // Pause at cnt=2 of slot 01
        repeat (3) @(negedge clk);
        check("pause_pre_sel", {a_i1, a_i0}, 1);
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("pause_sel",   {a_i1, a_i0}, 1);
            check("pause_valid", a_valid, 0);
            check("pause_tick",  a_tick, 0);
        end
        en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("resume_sel",   {a_i1, a_i0}, 1);
            check("resume_valid", a_valid, (c != 0) ? 1 : 0);
        end
        @(negedge clk);
        check("resume_next_sel", {a_i1, a_i0}, 2);
        check("resume_tick", a_tick, 1);

        // Restart during slot 10
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_sel",   {a_i1, a_i0}, 0);
        check("restart_valid", a_valid, 0);
        check("restart_tick",  a_tick, 0);
        check("restart_wrap",  a_wrap, 0);
        check("b_restart_sel",   {b_i1, b_i0}, 0);
        check("b_restart_valid", b_valid, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom % 10) != 0;
            restart = ($urandom % 40) == 0;
            rst     = ($urandom % 200) == 0;
            @(negedge clk);
        end
        rst = 1'b0; restart = 1'b0; en = 1'b1;
        repeat (40) @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Time-multiplexed select generator that sits directly upstream of the 2-to-4 decoder. It produces the 2-bit select pair `I1`/`I0`, cycling 0→1→2→3→0 with a programmable dwell per slot. It also produces a `Valid` strobe that gates the decoder outputs, with a blanking interval at the start of each slot to avoid ghosting on multiplexed displays or indicators. Single clock domain; pulse outputs mark slot advance and frame wrap.

## Interface
- `PRESCALE`, 4: clock cycles per slot; legal range ≥ 2.
- `BLANK`, 1: cycles at the start of each slot with `Valid` low; legal range 0 .. `PRESCALE`-1.
- One clock; reset is synchronous and active-high.
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  synchronous, active-high reset.
- `En`  in  1  run enable; low freezes the index and forces `Valid` low.
- `Restart`  in  1  one-cycle synchronous request: index→0, slot count→0.
- `I1`  out  1  select MSB, registered, to decoder `I1`.
- `I0`  out  1  select LSB, registered, to decoder `I0`.
- `Valid`  out  1  registered; high while the current select is to be displayed.
- `Tick`  out  1  registered one-cycle pulse in the first cycle of each new slot.
- `Wrap`  out  1  registered one-cycle pulse in the first cycle of slot 0 after 3→0.

## Operation
- State machine has three states:
  - **IDLE**: `En` low or just reset.
  - **BLANK**: slot count < `BLANK`.
  - **SHOW**: slot count ≥ `BLANK`.
- Internal slot counter `cnt` has width ceil(log2(`PRESCALE`)); index `idx` is 2 bits; `{I1,I0}` = `idx`.
- IDLE → BLANK when `En`=1. If `BLANK`=0, IDLE → SHOW directly. On entry, `cnt`=0.
- BLANK → SHOW when `cnt` reaches `BLANK`.
- At `cnt`=`PRESCALE`-1 with `En`=1, the next edge does all of the following:
  - `cnt`→0
  - `idx`→`idx`+1 mod 4
  - `Tick`=1
  - `Wrap`=1 if the new `idx`=0
  - state→BLANK, or SHOW if `BLANK`=0.
- `En`=0 in any state: next edge → IDLE. `cnt`→0, `idx` holds, `Valid`=0, no `Tick`/`Wrap`.
- `Restart`=1 forces `idx`→0 and `cnt`→0. The state becomes BLANK/SHOW per `BLANK` if `En`=1, otherwise IDLE. No `Tick` or `Wrap` is generated.
- Priority: `Rst` > `Restart` > `En`=0 > normal advance.
- `Valid` = 1 exactly when the registered state is SHOW.

## Timing
- Reset values: `I1`=0, `I0`=0, `Valid`=0, `Tick`=0, `Wrap`=0, state IDLE, `cnt`=0.
- `En` is sampled at edge k. After edge k the slot begins: `cnt`=0, `Valid`=(`BLANK`==0).
- Each slot lasts exactly `PRESCALE` cycles.
- `Valid` is high for `PRESCALE`-`BLANK` consecutive cycles per slot, in the last cycles of the slot.
- A frame is 4·`PRESCALE` cycles. `Wrap` has period 4·`PRESCALE` under continuous `En`.
- `I1`/`I0` change only on the edge that also asserts `Tick` (or on `Restart`/`Rst`). With `BLANK`≥1, `Valid` is therefore always low in the cycle the select changes.
- `Rst` during any state takes effect at the next edge, regardless of `En`/`Restart`.
- `En` dropping mid-slot discards the partial slot. On re-enable, the same index restarts its slot from `cnt`=0.

## Structure
- Shared package/include `scan_pkg` holds:
  - state encodings: IDLE=2'b00, BLANK=2'b01, SHOW=2'b10
  - the `cnt` width function.
- One sub-module, `slot_counter`: a parameterised modulo-`PRESCALE` counter with sync clear and a terminal-count output, instanced once.
- The top level holds the FSM, the index register and the pulse registers.
- Synthesizable; no latches; all outputs driven from flops.

## Test plan
All scenarios use `PRESCALE`=4, `BLANK`=1 unless noted.
- **Reset**: `Rst`=1 for 2 cycles with `En`=1 → `I1`/`I0`/`Valid`/`Tick`/`Wrap` all 0 throughout. The first slot starts on the edge after `Rst` falls.
- **Steady scan**: `En`=1 for 20 cycles →
  - select sequence 00 (4 cycles), 01, 10, 11, 00
  - `Valid` pattern 0,1,1,1 per slot
  - `Tick` at cycles 4, 8, 12, 16
  - `Wrap` only at 16.
- **Pause**: drop `En` at `cnt`=2 of slot 01 for 3 cycles → `Valid`=0, select stays 01, no `Tick`. On resume, slot 01 runs a full 4 cycles.
- **Restart**: pulse `Restart` during slot 10 → next cycle select=00, `cnt`=0, `Valid`=0, `Tick`=0, `Wrap`=0.
- **`BLANK`=0, `PRESCALE`=2**: `Valid` constantly 1 while enabled, with select changing every 2 cycles.
- **Decoder integration**: feed `I1`/`I0` into the decoder, gated by `Valid` → exactly one of D3..D0 is high when `Valid`=1 and all are low otherwise. D0 is asserted again every 16 cycles.
